// File: rtl/my_block_sched.sv
// Scheduler for a bank of block tops sharing one search request.
// REF phase polls blocks in index order and keeps the first reference hit;
// BLOOM phase broadcasts the hit distance to every block and gathers the
// per-block bloom results; COMMIT pulses core_end so blocks write back.
// Every output is a flop whose next value is decoded from the next state,
// so outputs change together with the state they describe.
module my_block_sched #(
  parameter int NUM_BLK     = 4,
  parameter int DIST_WIDTH  = 14,
  parameter int IDX_WIDTH   = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DIST_WIDTH-1:0]         start_dist,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          ref_found,
  output logic [IDX_WIDTH-1:0]          ref_blk_idx,
  output logic [DIST_WIDTH-1:0]         ref_dist_o,
  output logic [NUM_BLK-1:0]            bloom_mask,
  output logic [1:0]                    blk_mode,
  output logic [NUM_BLK-1:0]            blk_sel,
  output logic [DIST_WIDTH-1:0]         blk_distance,
  output logic                          blk_core_end,
  input  logic [NUM_BLK-1:0]            blk_contains_ref,
  input  logic [NUM_BLK-1:0]            blk_ref_end,
  input  logic [NUM_BLK*DIST_WIDTH-1:0] blk_ref_dist,
  input  logic [NUM_BLK-1:0]            blk_contains_bloom,
  input  logic [NUM_BLK-1:0]            blk_bloom_end
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REF_ISSUE  = 3'd1,
    S_REF_WAIT   = 3'd2,
    S_BLOOM_WAIT = 3'd3,
    S_COMMIT     = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [1:0]            MODE_IDLE   = 2'b00;
  localparam logic [1:0]            MODE_REF    = 2'b01;
  localparam logic [1:0]            MODE_BLOOM  = 2'b10;
  localparam logic [9:0]            TIMER_MAX   = 10'd1023;
  localparam logic [9:0]            TIMEOUT_VAL = 10'(TIMEOUT_CYC);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX    = IDX_WIDTH'(NUM_BLK - 1);
  localparam logic [IDX_WIDTH-1:0]  IDX_ZERO    = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0]  IDX_ONE     = IDX_WIDTH'(1);
  localparam logic [NUM_BLK-1:0]    BLK_NONE    = {NUM_BLK{1'b0}};
  localparam logic [NUM_BLK-1:0]    BLK_ALL     = {NUM_BLK{1'b1}};
  localparam logic [NUM_BLK-1:0]    BLK_ONE     = NUM_BLK'(1);
  localparam logic [DIST_WIDTH-1:0] DIST_ZERO   = {DIST_WIDTH{1'b0}};

  // control state
  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [DIST_WIDTH-1:0]   sdist_q, sdist_d;
  logic [9:0]              timer_q, timer_d;
  logic [NUM_BLK-1:0]      seen_q, seen_d;

  // result registers
  logic                    ref_found_q, ref_found_d;
  logic [IDX_WIDTH-1:0]    ref_idx_q, ref_idx_d;
  logic [DIST_WIDTH-1:0]   ref_dist_q, ref_dist_d;
  logic [NUM_BLK-1:0]      bloom_mask_q, bloom_mask_d;
  logic                    err_q, err_d;

  // registered block-side and status outputs
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [1:0]              mode_q, mode_d;
  logic [NUM_BLK-1:0]      sel_q, sel_d;
  logic [DIST_WIDTH-1:0]   bdist_q, bdist_d;
  logic                    core_end_q, core_end_d;

  // helpers
  logic [9:0]              timer_inc_s;
  logic                    timeout_hit_s;
  logic [DIST_WIDTH-1:0]   cur_ref_dist_s;
  logic [NUM_BLK-1:0]      bloom_new_s;

  // Saturating wait timer increment and distance of the block being polled.
  always_comb begin
    timer_inc_s    = (timer_q == TIMER_MAX) ? timer_q : (timer_q + 10'd1);
    timeout_hit_s  = (timer_inc_s >= TIMEOUT_VAL);
    cur_ref_dist_s = blk_ref_dist[int'(idx_q) * DIST_WIDTH +: DIST_WIDTH];
    bloom_new_s    = blk_bloom_end & ~seen_q;
  end

  // Next-state and result-register logic for the scheduling sequence.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sdist_d      = sdist_q;
    timer_d      = timer_q;
    seen_d       = seen_q;
    ref_found_d  = ref_found_q;
    ref_idx_d    = ref_idx_q;
    ref_dist_d   = ref_dist_q;
    bloom_mask_d = bloom_mask_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sdist_d      = start_dist;
          idx_d        = IDX_ZERO;
          ref_found_d  = 1'b0;
          bloom_mask_d = BLK_NONE;
          err_d        = 1'b0;
          seen_d       = BLK_NONE;
          state_d      = S_REF_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REF_ISSUE: begin
        timer_d = 10'd0;
        state_d = S_REF_WAIT;
      end
      S_REF_WAIT: begin
        timer_d = timer_inc_s;
        if (blk_ref_end[idx_q]) begin
          // only the first hit is kept; later hits leave the result alone
          if (blk_contains_ref[idx_q] && !ref_found_q) begin
            ref_found_d = 1'b1;
            ref_idx_d   = idx_q;
            ref_dist_d  = cur_ref_dist_s;
          end else begin
            ref_found_d = ref_found_q;
          end
          if (idx_q == LAST_IDX) begin
            if (ref_found_d) begin
              timer_d = 10'd0;
              seen_d  = BLK_NONE;
              state_d = S_BLOOM_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_REF_ISSUE;
          end
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_REF_WAIT;
        end
      end
      S_BLOOM_WAIT: begin
        timer_d = timer_inc_s;
        // a block's result is taken on its first bloom_end only
        bloom_mask_d = (bloom_mask_q & ~bloom_new_s) | (blk_contains_bloom & bloom_new_s);
        seen_d       = seen_q | blk_bloom_end;
        if (seen_d == BLK_ALL) begin
          state_d = S_COMMIT;
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_BLOOM_WAIT;
        end
      end
      S_COMMIT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so outputs line up with it.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    core_end_d = (state_d == S_COMMIT);
    mode_d     = MODE_IDLE;
    sel_d      = BLK_NONE;
    bdist_d    = DIST_ZERO;
    case (state_d)
      S_REF_ISSUE, S_REF_WAIT: begin
        mode_d  = MODE_REF;
        sel_d   = BLK_ONE << idx_d;
        bdist_d = sdist_d;
      end
      S_BLOOM_WAIT: begin
        mode_d  = MODE_BLOOM;
        sel_d   = BLK_ALL;
        bdist_d = ref_dist_d;
      end
      default: begin
        mode_d  = MODE_IDLE;
        sel_d   = BLK_NONE;
        bdist_d = DIST_ZERO;
      end
    endcase
  end

  // State, result and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= IDX_ZERO;
      sdist_q      <= DIST_ZERO;
      timer_q      <= 10'd0;
      seen_q       <= BLK_NONE;
      ref_found_q  <= 1'b0;
      ref_idx_q    <= IDX_ZERO;
      ref_dist_q   <= DIST_ZERO;
      bloom_mask_q <= BLK_NONE;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mode_q       <= MODE_IDLE;
      sel_q        <= BLK_NONE;
      bdist_q      <= DIST_ZERO;
      core_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sdist_q      <= sdist_d;
      timer_q      <= timer_d;
      seen_q       <= seen_d;
      ref_found_q  <= ref_found_d;
      ref_idx_q    <= ref_idx_d;
      ref_dist_q   <= ref_dist_d;
      bloom_mask_q <= bloom_mask_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      bdist_q      <= bdist_d;
      core_end_q   <= core_end_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_q;
  assign ref_found    = ref_found_q;
  assign ref_blk_idx  = ref_idx_q;
  assign ref_dist_o   = ref_dist_q;
  assign bloom_mask   = bloom_mask_q;
  assign blk_mode     = mode_q;
  assign blk_sel      = sel_q;
  assign blk_distance = bdist_q;
  assign blk_core_end = core_end_q;

endmodule

// File: tb/tb_my_block_sched.sv
// Self-checking bench for my_block_sched. Block behaviour (ref/bloom latencies,
// hits, distances) is described per request by small tables; expected results
// and timing come from a request-level model of the scheduling rules.
module tb_my_block_sched;

  localparam int NB = 4;
  localparam int DW = 14;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DW-1:0]    start_dist = '0;
  logic             busy, done, err_timeout, ref_found;
  logic [IW-1:0]    ref_blk_idx;
  logic [DW-1:0]    ref_dist_o;
  logic [NB-1:0]    bloom_mask;
  logic [1:0]       blk_mode;
  logic [NB-1:0]    blk_sel;
  logic [DW-1:0]    blk_distance;
  logic             blk_core_end;
  logic [NB-1:0]    blk_contains_ref = '0;
  logic [NB-1:0]    blk_ref_end = '0;
  logic [NB*DW-1:0] blk_ref_dist = '0;
  logic [NB-1:0]    blk_contains_bloom = '0;
  logic [NB-1:0]    blk_bloom_end = '0;

  my_block_sched #(.NUM_BLK(NB), .DIST_WIDTH(DW), .IDX_WIDTH(IW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .start_dist(start_dist),
    .busy(busy), .done(done), .err_timeout(err_timeout), .ref_found(ref_found),
    .ref_blk_idx(ref_blk_idx), .ref_dist_o(ref_dist_o), .bloom_mask(bloom_mask),
    .blk_mode(blk_mode), .blk_sel(blk_sel), .blk_distance(blk_distance),
    .blk_core_end(blk_core_end), .blk_contains_ref(blk_contains_ref),
    .blk_ref_end(blk_ref_end), .blk_ref_dist(blk_ref_dist),
    .blk_contains_bloom(blk_contains_bloom), .blk_bloom_end(blk_bloom_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // per-request block behaviour tables
  int            ref_lat [NB];   // cycles after issue until ref_end (1 = first wait cycle)
  bit            hit     [NB];
  logic [DW-1:0] rdist   [NB];
  bit            bl      [NB];
  int            blat    [NB];   // bloom cycle index (0 = first) of first bloom_end

  // responder bookkeeping
  int prev_j = -1;
  int ref_age = 0;
  int bl_age = 0;

  // expected results
  int            e_done_cyc, e_idx, e_polled;
  bit            e_found, e_err, e_core;
  logic [DW-1:0] e_dist;
  logic [NB-1:0] e_mask;

  // Drive block inputs for the next edge from the outputs seen now.
  task automatic respond();
    logic [NB-1:0]    re, cr, be, cb;
    logic [NB*DW-1:0] rd;
    int j;
    re = NB'($urandom);
    cr = NB'($urandom);
    be = NB'($urandom);
    cb = NB'($urandom);
    rd = (NB*DW)'({$urandom(), $urandom()});
    if (blk_mode == 2'b01) begin
      j = 0;
      for (int i = 0; i < NB; i++) if (blk_sel[i]) j = i;
      if (j != prev_j) ref_age = 0; else ref_age++;
      prev_j = j;
      if (ref_age == 0) re[j] = 1'($urandom);
      else re[j] = (ref_age >= ref_lat[j]);
      if (ref_age > 0 && re[j]) begin
        cr[j] = hit[j];
        rd[j*DW +: DW] = rdist[j];
      end
    end else begin
      prev_j = -1;
    end
    if (blk_mode == 2'b10) begin
      for (int i = 0; i < NB; i++) begin
        if (bl_age == blat[i]) begin
          be[i] = 1'b1; cb[i] = bl[i];
        end else if (bl_age > blat[i]) begin
          cb[i] = ~bl[i];
        end else begin
          be[i] = 1'b0;
        end
      end
      bl_age++;
    end else begin
      bl_age = 0;
    end
    blk_ref_end = re; blk_contains_ref = cr; blk_ref_dist = rd;
    blk_bloom_end = be; blk_contains_bloom = cb;
  endtask

  // Request-level model: walk the blocks in order, then the bloom phase.
  task automatic compute_expected();
    int sum, maxb;
    sum = 0; e_found = 0; e_err = 0; e_polled = 0; e_idx = 0; e_dist = '0;
    e_mask = '0; e_core = 0;
    for (int i = 0; i < NB; i++) begin
      e_polled++;
      if (ref_lat[i] > TO) begin
        sum += 1 + TO; e_err = 1; break;
      end
      sum += 1 + ref_lat[i];
      if (hit[i] && !e_found) begin
        e_found = 1; e_idx = i; e_dist = rdist[i];
      end
    end
    if (e_err || !e_found) begin
      e_done_cyc = sum + 1;
    end else begin
      maxb = 0;
      for (int i = 0; i < NB; i++) if (blat[i] > maxb) maxb = blat[i];
      for (int i = 0; i < NB; i++) if (blat[i] < TO) e_mask[i] = bl[i];
      if (maxb >= TO) begin
        e_err = 1; e_done_cyc = sum + TO + 1;
      end else begin
        e_core = 1; e_done_cyc = sum + maxb + 1 + 2;
      end
    end
  endtask

  // Run one request through the scheduler and compare against the model.
  task automatic run_request(input string name, input logic [DW-1:0] sd);
    int cyc, done_cyc, viol, core_cnt, core_cyc, polled, next_j, last_j, j;
    compute_expected();
    @(negedge clk);
    start = 1'b1; start_dist = sd;
    respond();
    cyc = 0; done_cyc = -1; viol = 0; core_cnt = 0; core_cyc = -1;
    polled = 0; next_j = 0; last_j = -1;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) viol++;
      if (err_timeout !== 1'b0 && done !== 1'b1) viol++;
      if (blk_core_end === 1'b1) begin core_cnt++; core_cyc = cyc; end
      case (blk_mode)
        2'b01: begin
          if ($countones(blk_sel) != 1) viol++;
          if (blk_distance !== sd) viol++;
          j = 0;
          for (int i = 0; i < NB; i++) if (blk_sel[i]) j = i;
          if (j != last_j) begin
            if (j != next_j) viol++;
            next_j++; polled++; last_j = j;
          end
        end
        2'b10: begin
          if (blk_sel !== {NB{1'b1}}) viol++;
          if (blk_distance !== e_dist) viol++;
        end
        2'b00: if (blk_sel !== '0) viol++;
        default: viol++;
      endcase
      if (done === 1'b1) done_cyc = cyc;
      start = (done !== 1'b1) && ($urandom_range(0, 3) == 0);
      start_dist = DW'($urandom);
      respond();
    end
    start = 1'b0;
    checks++; if (done_cyc !== e_done_cyc) begin failures++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, e_done_cyc); end
    checks++; if (ref_found !== e_found) begin failures++;
      $display("FAIL %s ref_found got=%0b exp=%0b", name, ref_found, e_found); end
    if (e_found) begin
      checks++; if (ref_blk_idx !== IW'(e_idx)) begin failures++;
        $display("FAIL %s ref_blk_idx got=%0d exp=%0d", name, ref_blk_idx, e_idx); end
      checks++; if (ref_dist_o !== e_dist) begin failures++;
        $display("FAIL %s ref_dist_o got=%h exp=%h", name, ref_dist_o, e_dist); end
    end
    checks++; if (bloom_mask !== e_mask) begin failures++;
      $display("FAIL %s bloom_mask got=%b exp=%b", name, bloom_mask, e_mask); end
    checks++; if (err_timeout !== e_err) begin failures++;
      $display("FAIL %s err_timeout got=%0b exp=%0b", name, err_timeout, e_err); end
    checks++; if (core_cnt !== int'(e_core) || (e_core && core_cyc != done_cyc - 1)) begin
      failures++;
      $display("FAIL %s core_end got=%0d@%0d exp=%0d", name, core_cnt, core_cyc, e_core); end
    checks++; if (polled !== e_polled) begin failures++;
      $display("FAIL %s polled_blocks got=%0d exp=%0d", name, polled, e_polled); end
    checks++; if (viol !== 0) begin failures++;
      $display("FAIL %s protocol got=%0d exp=0", name, viol); end
    @(negedge clk);
    respond();
    checks++; if ({busy, done, ref_found, err_timeout} !== {1'b0, 1'b0, e_found, e_err}) begin
      failures++;
      $display("FAIL %s after_done got=%b exp=%b", name, {busy, done, ref_found, err_timeout},
               {1'b0, 1'b0, e_found, e_err}); end
  endtask

  task automatic set_default();
    for (int i = 0; i < NB; i++) begin
      ref_lat[i] = 1; hit[i] = 0; rdist[i] = DW'($urandom); bl[i] = 0; blat[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({done, err_timeout, ref_found, ref_blk_idx, ref_dist_o, bloom_mask,
                   blk_mode, blk_sel, blk_distance, blk_core_end} !== '0) begin failures++;
      $display("FAIL reset_outputs got=%b %b %b %h %h %b %b %b %h %b exp=0", done, err_timeout,
               ref_found, ref_blk_idx, ref_dist_o, bloom_mask, blk_mode, blk_sel,
               blk_distance, blk_core_end); end
    rst = 1'b0;
  endtask

  task automatic test_no_hit();
    set_default();
    run_request("t1_no_hit", 14'h0abc);
  endtask

  task automatic test_first_hit();
    set_default();
    hit[1] = 1; rdist[1] = 14'h0123; hit[3] = 1; rdist[3] = 14'h0456;
    bl[0] = 1; bl[2] = 1;
    for (int i = 0; i < NB; i++) blat[i] = $urandom_range(0, 4);
    run_request("t2_first_hit", 14'h1111);
  endtask

  task automatic test_bloom_order();
    set_default();
    hit[0] = 1; rdist[0] = 14'h2a5c;
    bl[0] = 1; bl[1] = 1; bl[2] = 0; bl[3] = 1;
    blat[3] = 0; blat[0] = 1; blat[2] = 1; blat[1] = 2;
    run_request("t3_bloom_order", 14'h0777);
  endtask

  task automatic test_timeout();
    set_default();
    hit[0] = 1; ref_lat[2] = NEVER;
    run_request("t4_ref_timeout", 14'h0042);
    set_default();
    hit[2] = 1; bl[1] = 1; blat[3] = TO + 1;
    run_request("t4_bloom_timeout", 14'h0043);
    set_default();
    run_request("t4_clear_err", 14'h0044);
  endtask

  task automatic test_reset_mid();
    int seen_bloom, bad;
    set_default();
    hit[0] = 1; ref_lat[0] = 4;
    for (int i = 0; i < NB; i++) blat[i] = 6;
    @(negedge clk); start = 1'b1; start_dist = 14'h00aa; respond();
    @(negedge clk); start = 1'b0; respond();
    @(negedge clk); start = 1'b1; start_dist = 14'h0155; respond();
    @(negedge clk); start = 1'b0;
    checks++; if ({blk_sel, blk_distance} !== {4'b0001, 14'h00aa}) begin failures++;
      $display("FAIL t5_busy_start got=%b/%h exp=0001/00aa", blk_sel, blk_distance); end
    respond();
    seen_bloom = 0;
    for (int c = 0; c < 40 && seen_bloom == 0; c++) begin
      @(negedge clk);
      if (blk_mode == 2'b10) seen_bloom = 1;
      respond();
    end
    checks++; if (seen_bloom !== 1) begin failures++;
      $display("FAIL t5_reach_bloom got=%0d exp=1", seen_bloom); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({blk_mode, blk_sel, busy, done, ref_found, bloom_mask} !== '0) begin
      failures++;
      $display("FAIL t5_reset_mid got=%b %b %b %b %b %b exp=0", blk_mode, blk_sel, busy, done,
               ref_found, bloom_mask); end
    respond();
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || blk_core_end !== 1'b0 || busy !== 1'b0) bad++;
      respond();
    end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL t5_no_done_after_abort got=%0d exp=0", bad); end
  endtask

  task automatic test_last_hit();
    set_default();
    hit[3] = 1; rdist[3] = 14'h3def; bl[3] = 1; bl[1] = 1;
    blat[0] = 2; blat[1] = 0; blat[2] = 3; blat[3] = 1;
    run_request("t6_last_hit", 14'h0909);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NB; i++) begin
        ref_lat[i] = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(1, 5);
        hit[i] = 1'($urandom);
        rdist[i] = DW'($urandom);
        bl[i] = 1'($urandom);
        blat[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 5);
      end
      run_request($sformatf("rand%0d", n), DW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_no_hit();
    test_first_hit();
    test_bloom_order();
    test_timeout();
    test_reset_mid();
    test_last_hit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
